// File: rtl/cmsdk_mcu_rst_seq_pkg.sv
// Shared types and constants for the MCU reset sequencer.
package cmsdk_mcu_rst_seq_pkg;

    typedef enum logic [1:0] {
        StAssert = 2'd0,
        StRelP   = 2'd1,
        StRelH   = 2'd2,
        StRun    = 2'd3
    } rst_state_e;

    // Cause-bit positions above the NUM_REQ request bits
    localparam int unsigned CauseNrstOfs = 0;
    localparam int unsigned CausePorOfs  = 1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmsdk_mcu_rst_sync.sv
// Two-flop synchroniser with asynchronous reset to a configurable value.
module cmsdk_mcu_rst_sync #(
    parameter logic RstVal = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {2{RstVal}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/cmsdk_mcu_rst_seq.sv
// MCU reset sequencer: merges reset sources, enforces a minimum hold, releases
// PRESETn then HRESETn, tracks a sticky cause register and a debug reset.
module cmsdk_mcu_rst_seq
    import cmsdk_mcu_rst_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic               FCLK,
    input  logic               PORESETn,
    input  logic               NRST,
    input  logic [NUM_REQ-1:0] sys_reset_req,
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic               DBGRESETREQ,
    input  logic               RSTBYPASS,
    input  logic               rst_cause_clr,
    output logic               HRESETn,
    output logic               PRESETn,
    output logic               DBGRESETn,
    output logic [NUM_REQ+1:0] rst_cause,
    output logic               rst_busy
);

    localparam int unsigned HoldW  = cnt_width(HOLD_CYCLES);
    localparam int unsigned GapW   = cnt_width(STAGE_GAP);
    localparam int unsigned CauseW = NUM_REQ + 2;

    localparam logic [HoldW-1:0]  HoldMax  = HoldW'(HOLD_CYCLES - 1);
    localparam logic [GapW-1:0]   GapMax   = GapW'(STAGE_GAP - 1);
    localparam logic [CauseW-1:0] CausePor = CauseW'(1) << (NUM_REQ + CausePorOfs);

    logic              w_por_s;
    logic              w_nrst_s;
    logic              w_trig;
    logic              w_prel;
    logic [CauseW-1:0] w_set;
    logic [CauseW-1:0] w_cause_nxt;

    rst_state_e        r_state, w_state_nxt;
    logic [HoldW-1:0]  r_hold, w_hold_nxt;
    logic [GapW-1:0]   r_gap, w_gap_nxt;
    logic              r_presetn, r_hresetn, r_busy;
    logic [CauseW-1:0] r_cause;

    logic              r_dbgn, w_dbgn_nxt;
    logic              r_dbg_act, w_dbg_act_nxt;
    logic [HoldW-1:0]  r_dbg_cnt, w_dbg_cnt_nxt;
    logic              r_por_pend, w_por_pend_nxt;

    cmsdk_mcu_rst_sync #(
        .RstVal (1'b0)
    ) u_por_sync (
        .i_clk   (FCLK),
        .i_rst_n (PORESETn),
        .i_d     (1'b1),
        .o_q     (w_por_s)
    );

    // Resets to "not asserted" so power-on does not log a spurious NRST cause
    cmsdk_mcu_rst_sync #(
        .RstVal (1'b1)
    ) u_nrst_sync (
        .i_clk   (FCLK),
        .i_rst_n (PORESETn),
        .i_d     (NRST),
        .o_q     (w_nrst_s)
    );

    assign w_trig = (|(sys_reset_req & req_mask)) | ~w_nrst_s;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StAssert: if (r_hold == HoldMax && !w_trig && w_por_s) w_state_nxt = StRelP;
            StRelP: begin
                if (w_trig)               w_state_nxt = StAssert;
                else if (r_gap == GapMax) w_state_nxt = StRelH;
            end
            StRelH:  w_state_nxt = w_trig ? StAssert : StRun;
            StRun:   if (w_trig) w_state_nxt = StAssert;
            default: w_state_nxt = StAssert;
        endcase
    end

    always_comb begin
        w_hold_nxt = '0;
        if (r_state == StAssert && w_state_nxt == StAssert) begin
            w_hold_nxt = (w_por_s && r_hold != HoldMax) ? r_hold + 1'b1 : r_hold;
        end
        w_gap_nxt = '0;
        if (r_state == StRelP && w_state_nxt == StRelP) begin
            w_gap_nxt = r_gap + 1'b1;
        end
    end

    always_comb begin
        w_set                         = '0;
        w_set[NUM_REQ-1:0]            = sys_reset_req & req_mask;
        w_set[NUM_REQ + CauseNrstOfs] = ~w_nrst_s;
        w_cause_nxt = (rst_cause_clr ? '0 : r_cause) | w_set;
    end

    assign w_prel = (r_state == StAssert) && (w_state_nxt == StRelP);

    // Debug reset: first released alongside PRESETn after power-on, then
    // only DBGRESETREQ can assert it, with its own minimum hold.
    always_comb begin
        w_dbgn_nxt     = r_dbgn;
        w_dbg_act_nxt  = r_dbg_act;
        w_dbg_cnt_nxt  = r_dbg_cnt;
        w_por_pend_nxt = r_por_pend;
        if (r_por_pend && w_prel) w_por_pend_nxt = 1'b0;
        if (!r_dbg_act) begin
            if (DBGRESETREQ) begin
                w_dbg_act_nxt = 1'b1;
                w_dbg_cnt_nxt = '0;
                w_dbgn_nxt    = 1'b0;
            end else if (r_por_pend && w_prel) begin
                w_dbgn_nxt = 1'b1;
            end
        end else if (r_dbg_cnt != HoldMax) begin
            w_dbg_cnt_nxt = r_dbg_cnt + 1'b1;
        end else if (!DBGRESETREQ) begin
            w_dbg_act_nxt = 1'b0;
            w_dbg_cnt_nxt = '0;
            w_dbgn_nxt    = ~w_por_pend_nxt;
        end
    end

    always_ff @(posedge FCLK or negedge PORESETn) begin
        if (!PORESETn) begin
            r_state    <= StAssert;
            r_hold     <= '0;
            r_gap      <= '0;
            r_presetn  <= 1'b0;
            r_hresetn  <= 1'b0;
            r_busy     <= 1'b1;
            r_cause    <= CausePor;
            r_dbgn     <= 1'b0;
            r_dbg_act  <= 1'b0;
            r_dbg_cnt  <= '0;
            r_por_pend <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_gap      <= w_gap_nxt;
            r_presetn  <= (w_state_nxt != StAssert);
            r_hresetn  <= (w_state_nxt == StRelH) || (w_state_nxt == StRun);
            r_busy     <= (w_state_nxt != StRun);
            r_cause    <= w_cause_nxt;
            r_dbgn     <= w_dbgn_nxt;
            r_dbg_act  <= w_dbg_act_nxt;
            r_dbg_cnt  <= w_dbg_cnt_nxt;
            r_por_pend <= w_por_pend_nxt;
        end
    end

    assign HRESETn   = RSTBYPASS ? PORESETn : r_hresetn;
    assign PRESETn   = RSTBYPASS ? PORESETn : r_presetn;
    assign DBGRESETn = RSTBYPASS ? PORESETn : r_dbgn;
    assign rst_cause = r_cause;
    assign rst_busy  = r_busy;

endmodule

// File: tb/tb_cmsdk_mcu_rst_seq.sv
// Self-checking bench for cmsdk_mcu_rst_seq: randomized scenarios against
// release times derived from the hold/gap/synchroniser rules.
module tb_cmsdk_mcu_rst_seq;

    localparam int NReq = 4;
    localparam int Hold = 16;
    localparam int Gap  = 4;
    localparam int Sync = 2;
    localparam int CW   = NReq + 2;

    logic            fclk;
    logic            poresetn;
    logic            nrst;
    logic [NReq-1:0] req;
    logic [NReq-1:0] mask;
    logic            dbgreq;
    logic            bypass;
    logic            clr;
    logic            hresetn;
    logic            presetn;
    logic            dbgresetn;
    logic [CW-1:0]   cause;
    logic            busy;

    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] exp_cause;

    cmsdk_mcu_rst_seq #(
        .NUM_REQ     (NReq),
        .HOLD_CYCLES (Hold),
        .STAGE_GAP   (Gap)
    ) dut (
        .FCLK          (fclk),
        .PORESETn      (poresetn),
        .NRST          (nrst),
        .sys_reset_req (req),
        .req_mask      (mask),
        .DBGRESETREQ   (dbgreq),
        .RSTBYPASS     (bypass),
        .rst_cause_clr (clr),
        .HRESETn       (hresetn),
        .PRESETn       (presetn),
        .DBGRESETn     (dbgresetn),
        .rst_cause     (cause),
        .rst_busy      (busy)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_run: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        int p_at, h_at, b_at, d_at;
        poresetn = 1'b0; nrst = 1'b1; req = '0; mask = 4'hF;
        dbgreq = 1'b0; bypass = 1'b0; clr = 1'b0;
        repeat (3) step();
        exp_cause = CW'(1) << (NReq + 1);
        checks += 5;
        if (hresetn !== 1'b0) begin errors++; $display("FAIL rst_hresetn: got %b want 0", hresetn); end
        if (presetn !== 1'b0) begin errors++; $display("FAIL rst_presetn: got %b want 0", presetn); end
        if (dbgresetn !== 1'b0) begin errors++; $display("FAIL rst_dbgresetn: got %b want 0", dbgresetn); end
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
        if (cause !== exp_cause) begin errors++; $display("FAIL rst_cause: got %b want %b", cause, exp_cause); end
        poresetn = 1'b1;
        p_at = -1; h_at = -1; b_at = -1; d_at = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (p_at < 0 && presetn === 1'b1) p_at = k;
            if (h_at < 0 && hresetn === 1'b1) h_at = k;
            if (b_at < 0 && busy === 1'b0) b_at = k;
            if (d_at < 0 && dbgresetn === 1'b1) d_at = k;
        end
        checks += 5;
        if (p_at != Sync + Hold) begin errors++; $display("FAIL por_presetn_edge: got %0d want %0d", p_at, Sync + Hold); end
        if (h_at != Sync + Hold + Gap) begin errors++; $display("FAIL por_hresetn_edge: got %0d want %0d", h_at, Sync + Hold + Gap); end
        if (b_at != Sync + Hold + Gap + 1) begin errors++; $display("FAIL por_busy_edge: got %0d want %0d", b_at, Sync + Hold + Gap + 1); end
        if (d_at != Sync + Hold) begin errors++; $display("FAIL por_dbg_edge: got %0d want %0d", d_at, Sync + Hold); end
        if (cause !== exp_cause) begin errors++; $display("FAIL por_cause: got %b want %b", cause, exp_cause); end
    endtask

    task automatic test_sys_req();
        int b, len, rel, p_low, p_high, h_low, h_high, b_high, b_low;
        logic [NReq-1:0] rv;
        for (int it = 0; it < 4; it++) begin
            wait_run();
            b = $urandom_range(0, NReq - 1);
            len = (it == 0) ? 1 : $urandom_range(1, 40);
            mask = NReq'($urandom) | NReq'(1 << b);
            rv = NReq'(1 << b) | (NReq'($urandom) & ~mask);
            rel = 1 + ((len > Hold) ? len : Hold);
            exp_cause |= CW'(rv & mask);
            req = rv;
            p_low = -1; p_high = -1; h_low = -1; h_high = -1; b_high = -1; b_low = -1;
            for (int k = 1; k <= 80; k++) begin
                step();
                if (k == len) req = '0;
                if (p_low < 0 && presetn === 1'b0) p_low = k;
                if (p_low >= 0 && p_high < 0 && presetn === 1'b1) p_high = k;
                if (h_low < 0 && hresetn === 1'b0) h_low = k;
                if (h_low >= 0 && h_high < 0 && hresetn === 1'b1) h_high = k;
                if (b_high < 0 && busy === 1'b1) b_high = k;
                if (b_high >= 0 && b_low < 0 && busy === 1'b0) b_low = k;
            end
            checks += 5;
            if (p_low != 1 || h_low != 1) begin errors++; $display("FAIL req_assert_edge: got p=%0d h=%0d want 1", p_low, h_low); end
            if (p_high != rel) begin errors++; $display("FAIL req_presetn_rel: got %0d want %0d (len %0d)", p_high, rel, len); end
            if (h_high != rel + Gap) begin errors++; $display("FAIL req_hresetn_rel: got %0d want %0d", h_high, rel + Gap); end
            if (b_low != rel + Gap + 1) begin errors++; $display("FAIL req_busy_rel: got %0d want %0d", b_low, rel + Gap + 1); end
            if (cause !== exp_cause) begin errors++; $display("FAIL req_cause: got %b want %b", cause, exp_cause); end
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_cause = '0;
        checks++;
        if (cause !== exp_cause) begin errors++; $display("FAIL cause_clr: got %b want %b", cause, exp_cause); end
    endtask

    task automatic test_masked();
        int lows, busies, rel_at;
        wait_run();
        mask = 4'b1101;
        req = 4'b0010;
        lows = 0; busies = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (presetn !== 1'b1) lows++;
            if (busy !== 1'b0) busies++;
        end
        req = '0;
        checks += 3;
        if (lows != 0) begin errors++; $display("FAIL masked_presetn: got %0d low cycles want 0", lows); end
        if (busies != 0) begin errors++; $display("FAIL masked_busy: got %0d busy cycles want 0", busies); end
        if (cause !== exp_cause) begin errors++; $display("FAIL masked_cause: got %b want %b", cause, exp_cause); end
        req = 4'b0001;
        exp_cause |= CW'(1);
        lows = 0; rel_at = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 40) req = '0;
            if (presetn === 1'b0) lows++;
            if (lows > 0 && rel_at < 0 && presetn === 1'b1) rel_at = k;
        end
        checks += 3;
        if (lows != 40) begin errors++; $display("FAIL long_req_low: got %0d want 40", lows); end
        if (rel_at != 41) begin errors++; $display("FAIL long_req_rel: got %0d want 41", rel_at); end
        if (cause !== exp_cause) begin errors++; $display("FAIL long_req_cause: got %b want %b", cause, exp_cause); end
    endtask

    task automatic test_nrst_abort();
        int d, rel, p_low, p_high, h_high, dbg_lows;
        wait_run();
        mask = 4'hF;
        req = 4'b0001;
        step();
        req = '0;
        repeat (Hold + 1) step();
        checks++;
        if (presetn !== 1'b1 || hresetn !== 1'b0) begin
            errors++;
            $display("FAIL abort_setup: got p=%b h=%b want p=1 h=0", presetn, hresetn);
        end
        d = $urandom_range(1, 20);
        rel = Sync + 1 + ((d > Hold) ? d : Hold);
        exp_cause |= CW'(1) << NReq;
        nrst = 1'b0;
        p_low = -1; p_high = -1; h_high = -1; dbg_lows = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == d) nrst = 1'b1;
            if (p_low < 0 && presetn === 1'b0) p_low = k;
            if (p_low >= 0 && p_high < 0 && presetn === 1'b1) p_high = k;
            if (h_high < 0 && hresetn === 1'b1) h_high = k;
            if (dbgresetn !== 1'b1) dbg_lows++;
        end
        checks += 5;
        if (p_low != Sync + 1) begin errors++; $display("FAIL nrst_assert_edge: got %0d want %0d", p_low, Sync + 1); end
        if (p_high != rel) begin errors++; $display("FAIL nrst_presetn_rel: got %0d want %0d (d %0d)", p_high, rel, d); end
        if (h_high != rel + Gap) begin errors++; $display("FAIL nrst_hresetn_rel: got %0d want %0d", h_high, rel + Gap); end
        if (dbg_lows != 0) begin errors++; $display("FAIL nrst_dbg: got %0d low cycles want 0", dbg_lows); end
        if (cause !== exp_cause) begin errors++; $display("FAIL nrst_cause: got %b want %b", cause, exp_cause); end
    endtask

    task automatic test_dbg();
        int len, d_low, d_high, lows, sys_hits;
        for (int it = 0; it < 2; it++) begin
            wait_run();
            len = (it == 0) ? 1 : $urandom_range(2, 30);
            dbgreq = 1'b1;
            d_low = -1; d_high = -1; lows = 0; sys_hits = 0;
            for (int k = 1; k <= 50; k++) begin
                step();
                if (k == len) dbgreq = 1'b0;
                if (dbgresetn === 1'b0) lows++;
                if (d_low < 0 && dbgresetn === 1'b0) d_low = k;
                if (d_low >= 0 && d_high < 0 && dbgresetn === 1'b1) d_high = k;
                if (presetn !== 1'b1 || hresetn !== 1'b1 || busy !== 1'b0) sys_hits++;
            end
            checks += 4;
            if (d_low != 1) begin errors++; $display("FAIL dbg_assert_edge: got %0d want 1", d_low); end
            if (lows != ((len > Hold) ? len : Hold)) begin
                errors++;
                $display("FAIL dbg_low_len: got %0d want %0d (len %0d)", lows, (len > Hold) ? len : Hold, len);
            end
            if (sys_hits != 0) begin errors++; $display("FAIL dbg_sys_disturb: got %0d cycles want 0", sys_hits); end
            if (cause !== exp_cause) begin errors++; $display("FAIL dbg_cause: got %b want %b", cause, exp_cause); end
        end
    endtask

    task automatic test_bypass();
        wait_run();
        bypass = 1'b1;
        poresetn = 1'b0;
        #1;
        checks++;
        if ({hresetn, presetn, dbgresetn} !== 3'b000) begin
            errors++;
            $display("FAIL bypass_low: got %b want 000", {hresetn, presetn, dbgresetn});
        end
        poresetn = 1'b1;
        #1;
        checks++;
        if ({hresetn, presetn, dbgresetn} !== 3'b111) begin
            errors++;
            $display("FAIL bypass_high: got %b want 111", {hresetn, presetn, dbgresetn});
        end
        exp_cause = CW'(1) << (NReq + 1);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL bypass_busy: got %b want 1", busy); end
        if (cause !== exp_cause) begin errors++; $display("FAIL bypass_cause: got %b want %b", cause, exp_cause); end
        step();
        bypass = 1'b0;
        wait_run();
        mask = 4'hF;
        req = 4'b0100;
        clr = 1'b1;
        step();
        req = '0;
        clr = 1'b0;
        exp_cause = CW'(4'b0100);
        checks++;
        if (cause !== exp_cause) begin errors++; $display("FAIL clr_vs_set: got %b want %b", cause, exp_cause); end
        wait_run();
    endtask

    initial begin
        test_reset();
        test_sys_req();
        test_masked();
        test_nrst_abort();
        test_dbg();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
